// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit between the CPU datapath and the Bridge.
// Handles byte/half/word accesses, byte strobes, wait states, bus timeout and error counting.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic [7:0]        err_count,
  output logic              Bus_req,
  output logic [ADDR_W-1:0] Bus_addr,
  output logic              Bus_we,
  output logic [3:0]        Bus_wstrb,
  output logic [31:0]       Bus_wdata,
  input  logic              Bus_ack,
  input  logic [31:0]       Bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t            state;
  state_t            state_next;
  logic              lat_we;
  logic [1:0]        lat_size;
  logic              lat_uns;
  logic [ADDR_W-1:0] lat_addr;
  logic [3:0]        wstrb;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              err;
  logic [7:0]        wait_cnt;
  logic [7:0]        err_cnt;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] strobe(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   strobe = 4'b0001 << off;
      2'b01:   strobe = 4'b0011 << off;
      default: strobe = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   replicate = {4{d[7:0]}};
      2'b01:   replicate = {2{d[15:0]}};
      default: replicate = d;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [1:0] size, input logic uns,
                                          input logic [1:0] off, input logic [31:0] raw);
    logic [7:0]  b;
    logic [15:0] h;
    b = raw[{off, 3'b000} +: 8];
    h = raw[{off[1], 4'b0000} +: 16];
    case (size)
      2'b00:   extract = {{24{~uns & b[7]}}, b};
      2'b01:   extract = {{16{~uns & h[15]}}, h};
      default: extract = raw;
    endcase
  endfunction

  // State register
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state decode; an ack in the final wait cycle takes priority over timeout
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) state_next = is_misaligned(req_size, req_addr[1:0]) ? RESP : BUS;
        else           state_next = IDLE;
      end
      BUS: begin
        if (Bus_ack)                    state_next = RESP;
        else if (wait_cnt == LAST_WAIT) state_next = RESP;
        else                            state_next = BUS;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, wait counter, response data and error counter
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      lat_we   <= 1'b0;
      lat_size <= 2'b00;
      lat_uns  <= 1'b0;
      lat_addr <= '0;
      wstrb    <= 4'b0000;
      wdata    <= 32'h0000_0000;
      rdata    <= 32'h0000_0000;
      err      <= 1'b0;
      wait_cnt <= 8'd0;
      err_cnt  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we   <= req_we;
            lat_size <= req_size;
            lat_uns  <= req_unsigned;
            lat_addr <= req_addr;
            wstrb    <= req_we ? strobe(req_size, req_addr[1:0]) : 4'b0000;
            wdata    <= replicate(req_size, req_wdata);
            rdata    <= 32'h0000_0000;
            err      <= is_misaligned(req_size, req_addr[1:0]);
            wait_cnt <= 8'd0;
          end
        end
        BUS: begin
          if (Bus_ack) begin
            rdata <= lat_we ? 32'h0000_0000 : extract(lat_size, lat_uns, lat_addr[1:0], Bus_rdata);
            err   <= 1'b0;
          end else if (wait_cnt == LAST_WAIT) begin
            rdata <= 32'h0000_0000;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          if (err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign busy       = (state == BUS) || (state == RESP);
  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) && err;
  assign resp_rdata = rdata;
  assign err_count  = err_cnt;
  assign Bus_req    = (state == BUS);
  assign Bus_we     = (state == BUS) && lat_we;
  assign Bus_addr   = {lat_addr[ADDR_W-1:2], 2'b00};
  assign Bus_wstrb  = wstrb;
  assign Bus_wdata  = wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against an arithmetic reference model.
module tb_mem_access_unit;

  localparam int T = 4;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic [7:0]  err_count;
  logic        Bus_req;
  logic [31:0] Bus_addr;
  logic        Bus_we;
  logic [3:0]  Bus_wstrb;
  logic [31:0] Bus_wdata;
  logic        Bus_ack;
  logic [31:0] Bus_rdata;

  int vectors = 0;
  int errors  = 0;
  int ecnt    = 0;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(T)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy), .err_count(err_count),
    .Bus_req(Bus_req), .Bus_addr(Bus_addr), .Bus_we(Bus_we),
    .Bus_wstrb(Bus_wstrb), .Bus_wdata(Bus_wdata), .Bus_ack(Bus_ack),
    .Bus_rdata(Bus_rdata)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_mis(input logic [1:0] size, input int off);
    if (size == 2'd0)      return 1'b0;
    else if (size == 2'd1) return (off % 2) != 0;
    else                   return off != 0;
  endfunction

  function automatic logic [3:0] m_strb(input bit we, input logic [1:0] size, input int off);
    if (!we)               return 4'd0;
    else if (size == 2'd0) return 4'(1 << off);
    else if (size == 2'd1) return 4'(3 << off);
    else                   return 4'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] d);
    if (size == 2'd0)      return (d & 32'hFF) * 32'h0101_0101;
    else if (size == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    else                   return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input bit uns,
                                         input int off, input logic [31:0] raw);
    logic [31:0] lane;
    if (size == 2'd0) begin
      lane = (raw >> (8 * off)) & 32'hFF;
      if (!uns && lane >= 32'd128) lane = lane + 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      lane = (raw >> (16 * (off / 2))) & 32'hFFFF;
      if (!uns && lane >= 32'd32768) lane = lane + 32'hFFFF_0000;
    end else begin
      lane = raw;
    end
    return lane;
  endfunction

  // One complete access; called and returns on a falling edge. dly = ack after dly wait cycles.
  task automatic access(input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int dly, input logic [31:0] rd);
    int off, exp_cyc, exp_bus, bus_n;
    bit mis, exp_err, done;
    logic [31:0] exp_rd;
    off = int'(addr[1:0]);
    mis = m_mis(size, off);
    if (mis) begin
      exp_cyc = 1; exp_bus = 0; exp_err = 1'b1; exp_rd = 32'd0;
    end else if (dly < T) begin
      exp_cyc = 2 + dly; exp_bus = dly + 1; exp_err = 1'b0;
      exp_rd = we ? 32'd0 : m_load(size, uns, off, rd);
    end else begin
      exp_cyc = T + 1; exp_bus = T; exp_err = 1'b1; exp_rd = 32'd0;
    end
    Bus_ack = 1'b0;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge cpu_clk); @(negedge cpu_clk);
    req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
    bus_n = 0; done = 1'b0;
    for (int c = 1; c <= T + 8 && !done; c++) begin
      check("busy", {31'd0, busy}, 32'd1);
      if (Bus_req) begin
        check("bus_addr", Bus_addr, {addr[31:2], 2'b00});
        check("bus_we", {31'd0, Bus_we}, {31'd0, we});
        check("bus_wstrb", {28'd0, Bus_wstrb}, {28'd0, m_strb(we, size, off)});
        if (we) check("bus_wdata", Bus_wdata, m_wdata(size, wd));
        Bus_ack = (bus_n == dly);
        Bus_rdata = (bus_n == dly) ? rd : $urandom;
        bus_n++;
      end else begin
        Bus_ack = 1'($urandom_range(0, 1));
        Bus_rdata = $urandom;
      end
      if (resp_valid) begin
        check("resp_cycle", c, exp_cyc);
        check("bus_cycles", bus_n, exp_bus);
        check("resp_rdata", resp_rdata, exp_rd);
        check("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
        done = 1'b1;
      end
      @(posedge cpu_clk); @(negedge cpu_clk);
    end
    if (!done) check("resp_seen", 32'd0, 32'd1);
    Bus_ack = 1'b0;
    if (exp_err && ecnt < 255) ecnt++;
    check("err_count", {24'd0, err_count}, ecnt);
    check("resp_one_shot", {31'd0, resp_valid}, 32'd0);
    check("req_ready_after", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    cpu_rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h1000; req_wdata = 32'h5555_AAAA; Bus_ack = 1'b1; Bus_rdata = 32'd0;
    repeat (3) @(negedge cpu_clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_bus_req", {31'd0, Bus_req}, 32'd0);
    check("rst_bus_we", {31'd0, Bus_we}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    check("rst_wstrb", {28'd0, Bus_wstrb}, 32'd0);
    check("rst_wdata", Bus_wdata, 32'd0);
    check("rst_addr", Bus_addr, 32'd0);
    cpu_rst = 1'b0; req_valid = 1'b0; Bus_ack = 1'b0;
    @(negedge cpu_clk);

    access(1'b0, 2'd2, 1'b0, 32'h1000, 32'd0, 0, 32'hDEAD_BEEF);
    access(1'b0, 2'd0, 1'b0, 32'h1003, 32'd0, 0, 32'h80FF_FFFF);
    access(1'b0, 2'd0, 1'b1, 32'h1003, 32'd0, 1, 32'h80FF_FFFF);
    access(1'b1, 2'd1, 1'b0, 32'h2002, 32'h1234_ABCD, 3, 32'h0);
    access(1'b0, 2'd2, 1'b0, 32'h2001, 32'd0, 0, 32'h0);
    access(1'b0, 2'd1, 1'b0, 32'h2003, 32'd0, 0, 32'h0);
    access(1'b0, 2'd3, 1'b1, 32'h2004, 32'd0, 2, 32'h8765_4321);
    access(1'b0, 2'd1, 1'b0, 32'h2006, 32'd0, 0, 32'h8001_7FFF);
    access(1'b0, 2'd1, 1'b1, 32'h2006, 32'd0, 0, 32'h8001_7FFF);
    access(1'b1, 2'd0, 1'b0, 32'h3001, 32'hAB, T, 32'h0);

    // Reset pulsed mid-access
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h3000;
    @(posedge cpu_clk); @(negedge cpu_clk);
    req_valid = 1'b0; Bus_ack = 1'b0;
    @(posedge cpu_clk); @(negedge cpu_clk);
    check("mid_bus_req", {31'd0, Bus_req}, 32'd1);
    cpu_rst = 1'b1; req_valid = 1'b1;
    #1;
    check("rst_async_bus_req", {31'd0, Bus_req}, 32'd0);
    check("rst_async_busy", {31'd0, busy}, 32'd0);
    @(posedge cpu_clk); @(negedge cpu_clk);
    check("rst_no_resp", {31'd0, resp_valid}, 32'd0);
    cpu_rst = 1'b0; req_valid = 1'b0; ecnt = 0;
    check("rst_clears_errs", {24'd0, err_count}, 32'd0);
    @(posedge cpu_clk); @(negedge cpu_clk);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_no_resp", {31'd0, resp_valid}, 32'd0);
    access(1'b0, 2'd2, 1'b0, 32'h3000, 32'd0, 1, 32'hCAFE_F00D);

    for (int i = 0; i < 300; i++) access(1'b0, 2'd2, 1'b0, 32'h4000, 32'd0, 99, 32'h0);
    check("err_saturated", {24'd0, err_count}, 32'd255);

    for (int i = 0; i < 250; i++) begin
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom_range(0, 5), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
